// File: rtl/coord_link_rx.sv
// -----------------------------------------------------------------------------
// coord_link_rx
// Receives hand-coordinate frames from the second camera board over one UART
// wire. The frame is SYNC_BYTES sync bytes, then PAYLOAD_BYTES payload bytes,
// then one checksum byte that is the XOR of the payload bytes.
// Functions: oversampling byte receiver, sync-header hunting, payload
// unpacking, checksum check, inter-byte gap abort, link watchdog and a
// good-frame counter.
//
// Ports
//   clk_in            system clock (single domain)
//   rst_n_in          asynchronous active-low reset
//   rx_in             raw serial line, asynchronous, idles high
//   coords_out        last good coordinates, coord 0 in the most significant field
//   coords_valid_out  one-cycle pulse when coords_out updates
//   frame_err_out     one-cycle pulse on checksum mismatch or gap abort
//   byte_err_out      one-cycle pulse on a bad stop bit
//   frames_ok_out     saturating count of good frames
//   link_alive_out    high while a good frame was seen within TIMEOUT_CLKS
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module coord_link_rx #(
    parameter int         CLKS_PER_BIT = 564,
    parameter int         NUM_COORDS   = 4,
    parameter int         COORD_WIDTH  = 12,
    parameter int         SYNC_BYTES   = 3,
    parameter logic [7:0] SYNC_VALUE   = 8'hFF,
    parameter int         GAP_CLKS     = 20 * CLKS_PER_BIT,
    parameter int         TIMEOUT_CLKS = 6_500_000
) (
    input  logic                              clk_in,
    input  logic                              rst_n_in,
    input  logic                              rx_in,
    output logic [NUM_COORDS*COORD_WIDTH-1:0] coords_out,
    output logic                              coords_valid_out,
    output logic                              frame_err_out,
    output logic                              byte_err_out,
    output logic [15:0]                       frames_ok_out,
    output logic                              link_alive_out
);

    localparam int COORD_BITS    = NUM_COORDS * COORD_WIDTH;
    localparam int PAYLOAD_BYTES = (COORD_BITS + 7) / 8;
    localparam int PAYLOAD_BITS  = PAYLOAD_BYTES * 8;
    localparam int BIT_CNT_W     = $clog2(CLKS_PER_BIT);
    localparam int SYNC_W        = $clog2(SYNC_BYTES + 1);
    localparam int BYTE_CNT_W    = $clog2(PAYLOAD_BYTES + 1);
    localparam int GAP_W         = $clog2(GAP_CLKS + 1);
    localparam int WDOG_W        = $clog2(TIMEOUT_CLKS + 1);

    localparam logic [BIT_CNT_W-1:0]  BIT_ONE   = BIT_CNT_W'(1);
    localparam logic [BIT_CNT_W-1:0]  HALF_LAST = BIT_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [SYNC_W-1:0]     SYNC_ONE  = SYNC_W'(1);
    localparam logic [SYNC_W-1:0]     SYNC_LAST = SYNC_W'(SYNC_BYTES - 1);
    localparam logic [BYTE_CNT_W-1:0] BYTE_ONE  = BYTE_CNT_W'(1);
    localparam logic [BYTE_CNT_W-1:0] PB_LAST   = BYTE_CNT_W'(PAYLOAD_BYTES - 1);
    localparam logic [GAP_W-1:0]      GAP_ONE   = GAP_W'(1);
    localparam logic [GAP_W-1:0]      GAP_LAST  = GAP_W'(GAP_CLKS - 1);
    localparam logic [WDOG_W-1:0]     WDOG_ONE  = WDOG_W'(1);
    localparam logic [WDOG_W-1:0]     WDOG_ZERO = WDOG_W'(0);
    localparam logic [WDOG_W-1:0]     WDOG_LOAD = WDOG_W'(TIMEOUT_CLKS);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        FR_HUNT    = 2'd0,
        FR_PAYLOAD = 2'd1,
        FR_CHECK   = 2'd2
    } fr_state_t;

    // synchroniser
    logic rx_meta_r, rx_sync_r;

    // byte receiver
    rx_state_t             rx_state_r, rx_state_s;
    logic [BIT_CNT_W-1:0]  bit_cnt_r,  bit_cnt_s;
    logic [2:0]            bit_idx_r,  bit_idx_s;
    logic [7:0]            shift_r,    shift_s;
    logic                  byte_valid_r, byte_valid_s;
    logic                  byte_err_r,   byte_err_s;

    // framer, timers and outputs
    fr_state_t             fr_state_r,  fr_state_s;
    logic [SYNC_W-1:0]     sync_cnt_r,  sync_cnt_s;
    logic [BYTE_CNT_W-1:0] byte_cnt_r,  byte_cnt_s;
    logic [PAYLOAD_BITS-1:0] payload_r, payload_s;
    logic [7:0]            xor_r,       xor_s;
    logic [GAP_W-1:0]      gap_r,       gap_s;
    logic [WDOG_W-1:0]     wdog_r,      wdog_s;
    logic                  alive_r,     alive_s;
    logic [COORD_BITS-1:0] coords_r,    coords_s;
    logic                  coords_valid_r, coords_valid_s;
    logic                  frame_err_r, frame_err_s;
    logic [15:0]           frames_r,    frames_s;
    logic                  good_frame_s;

    // Two-flop synchroniser for the asynchronous line; idle level is high.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_in;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Byte receiver next-state: start-bit qualification at mid-bit, then
    // one sample per bit period (LSB first), then the stop-bit verdict.
    always_comb begin
        rx_state_s   = rx_state_r;
        bit_cnt_s    = bit_cnt_r;
        bit_idx_s    = bit_idx_r;
        shift_s      = shift_r;
        byte_valid_s = 1'b0;
        byte_err_s   = 1'b0;
        case (rx_state_r)
            RX_IDLE: begin
                bit_cnt_s = '0;
                if (!rx_sync_r) begin
                    rx_state_s = RX_START;
                end else begin
                    rx_state_s = RX_IDLE;
                end
            end
            RX_START: begin
                if (bit_cnt_r == HALF_LAST) begin
                    bit_cnt_s = '0;
                    bit_idx_s = 3'd0;
                    // A line back high at mid-start is a glitch: drop it silently.
                    if (!rx_sync_r) begin
                        rx_state_s = RX_DATA;
                    end else begin
                        rx_state_s = RX_IDLE;
                    end
                end else begin
                    bit_cnt_s = bit_cnt_r + BIT_ONE;
                end
            end
            RX_DATA: begin
                if (bit_cnt_r == BIT_LAST) begin
                    bit_cnt_s = '0;
                    shift_s   = {rx_sync_r, shift_r[7:1]};
                    if (bit_idx_r == 3'd7) begin
                        rx_state_s = RX_STOP;
                    end else begin
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    bit_cnt_s = bit_cnt_r + BIT_ONE;
                end
            end
            RX_STOP: begin
                if (bit_cnt_r == BIT_LAST) begin
                    bit_cnt_s  = '0;
                    rx_state_s = RX_IDLE;
                    if (rx_sync_r) begin
                        byte_valid_s = 1'b1;
                    end else begin
                        byte_err_s = 1'b1;
                    end
                end else begin
                    bit_cnt_s = bit_cnt_r + BIT_ONE;
                end
            end
            default: begin
                rx_state_s = RX_IDLE;
                bit_cnt_s  = '0;
            end
        endcase
    end

    // Byte receiver state register.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rx_state_r   <= RX_IDLE;
            bit_cnt_r    <= '0;
            bit_idx_r    <= 3'd0;
            shift_r      <= 8'h00;
            byte_valid_r <= 1'b0;
            byte_err_r   <= 1'b0;
        end else begin
            rx_state_r   <= rx_state_s;
            bit_cnt_r    <= bit_cnt_s;
            bit_idx_r    <= bit_idx_s;
            shift_r      <= shift_s;
            byte_valid_r <= byte_valid_s;
            byte_err_r   <= byte_err_s;
        end
    end

    // Framer next-state: header hunt, payload collection, checksum verdict,
    // gap abort, plus the output registers that only a good frame updates.
    always_comb begin
        fr_state_s     = fr_state_r;
        sync_cnt_s     = sync_cnt_r;
        byte_cnt_s     = byte_cnt_r;
        payload_s      = payload_r;
        xor_s          = xor_r;
        gap_s          = gap_r;
        coords_s       = coords_r;
        coords_valid_s = 1'b0;
        frame_err_s    = 1'b0;
        frames_s       = frames_r;
        good_frame_s   = 1'b0;
        if (byte_err_r) begin
            // A corrupted byte kills the frame without a frame error.
            fr_state_s = FR_HUNT;
            sync_cnt_s = '0;
            byte_cnt_s = '0;
            xor_s      = 8'h00;
            gap_s      = '0;
        end else begin
            case (fr_state_r)
                FR_HUNT: begin
                    gap_s = '0;
                    if (byte_valid_r) begin
                        if (shift_r == SYNC_VALUE) begin
                            if (sync_cnt_r == SYNC_LAST) begin
                                fr_state_s = FR_PAYLOAD;
                                sync_cnt_s = '0;
                                byte_cnt_s = '0;
                                xor_s      = 8'h00;
                            end else begin
                                sync_cnt_s = sync_cnt_r + SYNC_ONE;
                            end
                        end else begin
                            sync_cnt_s = '0;
                        end
                    end else begin
                        sync_cnt_s = sync_cnt_r;
                    end
                end
                FR_PAYLOAD: begin
                    if (byte_valid_r) begin
                        gap_s     = '0;
                        payload_s = (payload_r << 4'd8) | PAYLOAD_BITS'(shift_r);
                        xor_s     = xor_r ^ shift_r;
                        if (byte_cnt_r == PB_LAST) begin
                            fr_state_s = FR_CHECK;
                        end else begin
                            byte_cnt_s = byte_cnt_r + BYTE_ONE;
                        end
                    end else if (gap_r == GAP_LAST) begin
                        frame_err_s = 1'b1;
                        fr_state_s  = FR_HUNT;
                        sync_cnt_s  = '0;
                        byte_cnt_s  = '0;
                        xor_s       = 8'h00;
                        gap_s       = '0;
                    end else begin
                        gap_s = gap_r + GAP_ONE;
                    end
                end
                FR_CHECK: begin
                    if (byte_valid_r) begin
                        if (shift_r == xor_r) begin
                            good_frame_s   = 1'b1;
                            // Pad bits sit at the bottom of the payload and are dropped.
                            coords_s       = payload_r[PAYLOAD_BITS-1 -: COORD_BITS];
                            coords_valid_s = 1'b1;
                            if (frames_r != 16'hFFFF) begin
                                frames_s = frames_r + 16'd1;
                            end else begin
                                frames_s = frames_r;
                            end
                        end else begin
                            frame_err_s = 1'b1;
                        end
                        fr_state_s = FR_HUNT;
                        sync_cnt_s = '0;
                        byte_cnt_s = '0;
                        xor_s      = 8'h00;
                        gap_s      = '0;
                    end else if (gap_r == GAP_LAST) begin
                        frame_err_s = 1'b1;
                        fr_state_s  = FR_HUNT;
                        sync_cnt_s  = '0;
                        byte_cnt_s  = '0;
                        xor_s       = 8'h00;
                        gap_s       = '0;
                    end else begin
                        gap_s = gap_r + GAP_ONE;
                    end
                end
                default: begin
                    fr_state_s = FR_HUNT;
                    sync_cnt_s = '0;
                    byte_cnt_s = '0;
                    xor_s      = 8'h00;
                    gap_s      = '0;
                end
            endcase
        end
    end

    // Link watchdog: reloads on a good frame; alive drops on the edge the count hits zero.
    always_comb begin
        wdog_s  = wdog_r;
        alive_s = alive_r;
        if (good_frame_s) begin
            wdog_s  = WDOG_LOAD;
            alive_s = 1'b1;
        end else if (wdog_r != WDOG_ZERO) begin
            wdog_s  = wdog_r - WDOG_ONE;
            alive_s = (wdog_r != WDOG_ONE);
        end else begin
            wdog_s  = WDOG_ZERO;
            alive_s = 1'b0;
        end
    end

    // Framer, watchdog and output registers.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            fr_state_r     <= FR_HUNT;
            sync_cnt_r     <= '0;
            byte_cnt_r     <= '0;
            payload_r      <= '0;
            xor_r          <= 8'h00;
            gap_r          <= '0;
            wdog_r         <= '0;
            alive_r        <= 1'b0;
            coords_r       <= '0;
            coords_valid_r <= 1'b0;
            frame_err_r    <= 1'b0;
            frames_r       <= 16'h0000;
        end else begin
            fr_state_r     <= fr_state_s;
            sync_cnt_r     <= sync_cnt_s;
            byte_cnt_r     <= byte_cnt_s;
            payload_r      <= payload_s;
            xor_r          <= xor_s;
            gap_r          <= gap_s;
            wdog_r         <= wdog_s;
            alive_r        <= alive_s;
            coords_r       <= coords_s;
            coords_valid_r <= coords_valid_s;
            frame_err_r    <= frame_err_s;
            frames_r       <= frames_s;
        end
    end

    assign coords_out       = coords_r;
    assign coords_valid_out = coords_valid_r;
    assign frame_err_out    = frame_err_r;
    assign byte_err_out     = byte_err_r;
    assign frames_ok_out    = frames_r;
    assign link_alive_out   = alive_r;

endmodule

// File: tb/tb_coord_link_rx.sv
// -----------------------------------------------------------------------------
// tb_coord_link_rx
// Drives serial frames into two receiver instances (4x12-bit and 3x10-bit)
// and compares pulse counts, coordinates and status against a byte-level
// reference model of the framing rules.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_coord_link_rx;

    localparam int CPB = 16;
    localparam int TO  = 4000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a_n, rst_b_n, rx_a, rx_b;
    logic [47:0] coords_a;
    logic [29:0] coords_b;
    logic cv_a, fe_a, be_a, alive_a;
    logic cv_b, fe_b, be_b, alive_b;
    logic [15:0] fok_a, fok_b;

    coord_link_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut_a (
        .clk_in(clk), .rst_n_in(rst_a_n), .rx_in(rx_a),
        .coords_out(coords_a), .coords_valid_out(cv_a), .frame_err_out(fe_a),
        .byte_err_out(be_a), .frames_ok_out(fok_a), .link_alive_out(alive_a));

    coord_link_rx #(.CLKS_PER_BIT(CPB), .NUM_COORDS(3), .COORD_WIDTH(10), .TIMEOUT_CLKS(TO)) dut_b (
        .clk_in(clk), .rst_n_in(rst_b_n), .rx_in(rx_b),
        .coords_out(coords_b), .coords_valid_out(cv_b), .frame_err_out(fe_b),
        .byte_err_out(be_b), .frames_ok_out(fok_b), .link_alive_out(alive_b));

    int checks = 0;
    int errors = 0;

    // observed pulse counts and times, per line (0 = dut_a, 1 = dut_b)
    int     n_cv[2] = '{0, 0};
    int     n_fe[2] = '{0, 0};
    int     n_be[2] = '{0, 0};
    longint t_cv[2] = '{0, 0};
    longint t_fe[2] = '{0, 0};
    longint t_start[2] = '{0, 0};

    // reference model state
    int          m_pb[2]   = '{6, 4};
    int          m_bits[2] = '{48, 30};
    int          m_sync[2];
    bit          m_in[2];
    int          m_cnt[2];
    logic [63:0] m_acc[2];
    logic [7:0]  m_x[2];
    logic [63:0] e_coords[2];
    int          e_cv[2], e_fe[2], e_be[2], e_fok[2];

    logic [7:0] q[$];

    // Pulse monitor.
    always @(negedge clk) begin
        if (cv_a) begin n_cv[0] = n_cv[0] + 1; t_cv[0] = $time; end
        if (fe_a) begin n_fe[0] = n_fe[0] + 1; t_fe[0] = $time; end
        if (be_a) n_be[0] = n_be[0] + 1;
        if (cv_b) begin n_cv[1] = n_cv[1] + 1; t_cv[1] = $time; end
        if (fe_b) begin n_fe[1] = n_fe[1] + 1; t_fe[1] = $time; end
        if (be_b) n_be[1] = n_be[1] + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int l);
        m_sync[l] = 0; m_in[l] = 1'b0; m_cnt[l] = 0; m_acc[l] = 64'd0; m_x[l] = 8'h00;
        e_coords[l] = 64'd0; e_fok[l] = 0;
    endtask

    // Framing rules applied to one correctly received byte.
    task automatic model_byte(input int l, input logic [7:0] b);
        if (!m_in[l]) begin
            if (b == 8'hFF) begin
                m_sync[l]++;
                if (m_sync[l] == 3) begin
                    m_in[l] = 1'b1; m_cnt[l] = 0; m_acc[l] = 64'd0; m_x[l] = 8'h00; m_sync[l] = 0;
                end
            end else begin
                m_sync[l] = 0;
            end
        end else if (m_cnt[l] < m_pb[l]) begin
            m_acc[l] = (m_acc[l] << 8) | {56'd0, b};
            m_x[l]   = m_x[l] ^ b;
            m_cnt[l]++;
        end else begin
            if (b == m_x[l]) begin
                e_coords[l] = m_acc[l] >> (m_pb[l] * 8 - m_bits[l]);
                e_cv[l]++;
                if (e_fok[l] < 65535) e_fok[l]++;
            end else begin
                e_fe[l]++;
            end
            m_in[l] = 1'b0; m_sync[l] = 0;
        end
    endtask

    task automatic model_byte_err(input int l);
        e_be[l]++; m_in[l] = 1'b0; m_sync[l] = 0;
    endtask

    task automatic model_gap(input int l);
        if (m_in[l]) begin e_fe[l]++; m_in[l] = 1'b0; end
    endtask

    task automatic drive(input int l, input logic v);
        if (l == 0) rx_a = v; else rx_b = v;
    endtask

    // One UART byte: start, 8 data bits LSB first, stop (optionally forced low).
    task automatic send_byte(input int l, input logic [7:0] b, input logic stop_ok);
        logic [9:0] fb;
        fb = {stop_ok, b, 1'b0};
        @(negedge clk);
        t_start[l] = $time;
        for (int i = 0; i < 10; i++) begin
            drive(l, fb[i]);
            repeat (CPB) @(negedge clk);
        end
        drive(l, 1'b1);
        if (stop_ok) begin
            model_byte(l, b);
        end else begin
            model_byte_err(l);
            repeat (2 * CPB) @(negedge clk);
        end
    endtask

    task automatic send_seq(input int l, input logic [7:0] bs[$]);
        for (int i = 0; i < bs.size(); i++) send_byte(l, bs[i], 1'b1);
    endtask

    function automatic logic [7:0] xsum(input logic [7:0] bs[$]);
        logic [7:0] x;
        x = 8'h00;
        for (int i = 0; i < bs.size(); i++) x = x ^ bs[i];
        return x;
    endfunction

    task automatic compare_all(input int l, input string tag);
        if (l == 0) begin
            check_val({tag, "_coords"}, 64'(coords_a), e_coords[0]);
            check_val({tag, "_fok"},    64'(fok_a),    64'(e_fok[0]));
        end else begin
            check_val({tag, "_coords"}, 64'(coords_b), e_coords[1]);
            check_val({tag, "_fok"},    64'(fok_b),    64'(e_fok[1]));
        end
        check_val({tag, "_cv_cnt"}, 64'(n_cv[l]), 64'(e_cv[l]));
        check_val({tag, "_fe_cnt"}, 64'(n_fe[l]), 64'(e_fe[l]));
        check_val({tag, "_be_cnt"}, 64'(n_be[l]), 64'(e_be[l]));
    endtask

    initial begin
        logic [7:0] pl[$];
        logic [7:0] ck;
        longint     d;
        int         mode, bad_idx;

        e_cv = '{0, 0}; e_fe = '{0, 0}; e_be = '{0, 0};
        model_reset(0); model_reset(1);
        rx_a = 1'b1; rx_b = 1'b1; rst_a_n = 1'b0; rst_b_n = 1'b0;
        repeat (3) @(negedge clk);
        compare_all(0, "rst_a");
        compare_all(1, "rst_b");
        check_val("rst_alive_a", 64'(alive_a), 64'd0);
        check_val("rst_cv_a",    64'(cv_a),    64'd0);
        rst_a_n = 1'b1; rst_b_n = 1'b1;
        repeat (5) @(negedge clk);

        // 1: nominal frame, output latency, link alive
        q = {8'hFF, 8'hFF, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'h2E};
        send_seq(0, q);
        repeat (2 * CPB) @(negedge clk);
        compare_all(0, "nominal");
        check_val("nominal_const", 64'(coords_a), 64'h0000_1234_5678_9ABC);
        check_val("nominal_alive", 64'(alive_a), 64'd1);
        d = (t_cv[0] - t_start[0]) / 10;
        check_val("latency_window", 64'((d >= 150 && d <= 160) ? 1 : 0), 64'd1);

        // watchdog: alive falls exactly TO cycles after the coords_valid edge
        d = ($time - t_cv[0]) / 10;
        repeat (TO - 1 - int'(d)) @(negedge clk);
        check_val("wdog_before", 64'(alive_a), 64'd1);
        @(negedge clk);
        check_val("wdog_after", 64'(alive_a), 64'd0);

        // 2: checksum mismatch, then a good frame
        q[9] = 8'h2F;
        send_seq(0, q);
        repeat (2 * CPB) @(negedge clk);
        compare_all(0, "bad_ck");
        q[9] = 8'h2E;
        send_seq(0, q);
        repeat (2 * CPB) @(negedge clk);
        compare_all(0, "after_bad_ck");
        check_val("after_bad_ck_alive", 64'(alive_a), 64'd1);

        // 3: bad stop bit on the third payload byte, then a full frame
        send_byte(0, 8'hFF, 1'b1); send_byte(0, 8'hFF, 1'b1); send_byte(0, 8'hFF, 1'b1);
        send_byte(0, 8'h11, 1'b1); send_byte(0, 8'h22, 1'b1); send_byte(0, 8'h33, 1'b0);
        repeat (2 * CPB) @(negedge clk);
        compare_all(0, "stop_err");
        pl = {8'h0F, 8'hED, 8'hCB, 8'hA9, 8'h87, 8'h65};
        q = {8'hFF, 8'hFF, 8'hFF};
        q = {q, pl, xsum(pl)};
        send_seq(0, q);
        repeat (2 * CPB) @(negedge clk);
        compare_all(0, "after_stop_err");

        // 4: short glitch, then broken header followed by a good frame
        @(negedge clk);
        rx_a = 1'b0;
        repeat (5) @(negedge clk);
        rx_a = 1'b1;
        repeat (60) @(negedge clk);
        compare_all(0, "glitch");
        pl = {8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB};
        q = {8'hFF, 8'h00, 8'hFF, 8'hFF, 8'hFF};
        q = {q, pl, xsum(pl)};
        send_seq(0, q);
        repeat (2 * CPB) @(negedge clk);
        compare_all(0, "sync_reset");

        // 5: gap abort mid-payload
        q = {8'hFF, 8'hFF, 8'hFF, 8'h12, 8'h34, 8'h56};
        send_seq(0, q);
        repeat (400) @(negedge clk);
        model_gap(0);
        compare_all(0, "gap");
        d = (t_fe[0] - t_start[0]) / 10;
        check_val("gap_window", 64'((d >= 466 && d <= 486) ? 1 : 0), 64'd1);

        // randomized frames: good, corrupted checksum, or bad stop bit
        for (int f = 0; f < 12; f++) begin
            mode = int'($urandom_range(0, 2));
            pl = {};
            for (int i = 0; i < 6; i++) pl.push_back(8'($urandom_range(0, 255)));
            ck = xsum(pl);
            if (mode == 1) ck = ck ^ (8'd1 << $urandom_range(0, 7));
            q = {8'hFF, 8'hFF, 8'hFF};
            q = {q, pl, ck};
            bad_idx = (mode == 2) ? int'($urandom_range(3, 9)) : -1;
            for (int i = 0; i < q.size(); i++) begin
                send_byte(0, q[i], (i != bad_idx));
                repeat ($urandom_range(0, 60)) @(negedge clk);
            end
            repeat (40) @(negedge clk);
            compare_all(0, $sformatf("rand%0d", f));
        end

        // 6: 3x10-bit instance with pad bits
        pl = {8'h80, 8'h40, 8'h20, 8'h1C};
        q = {8'hFF, 8'hFF, 8'hFF};
        q = {q, pl, 8'hFC};
        send_seq(1, q);
        repeat (2 * CPB) @(negedge clk);
        compare_all(1, "pad");

        // reset mid-payload clears outputs immediately; header must restart
        q = {8'hFF, 8'hFF, 8'hFF, 8'h80, 8'h40};
        send_seq(1, q);
        @(negedge clk);
        rst_b_n = 1'b0;
        #1;
        model_reset(1);
        compare_all(1, "midrst");
        check_val("midrst_alive", 64'(alive_b), 64'd0);
        @(negedge clk);
        rst_b_n = 1'b1;
        repeat (5) @(negedge clk);
        q = {8'hFF, 8'hFF, 8'h80, 8'h40, 8'h20, 8'h1C, 8'hFC};
        send_seq(1, q);
        repeat (2 * CPB) @(negedge clk);
        compare_all(1, "short_hdr");
        q = {8'hFF, 8'hFF, 8'hFF, 8'h80, 8'h40, 8'h20, 8'h1C, 8'hFC};
        send_seq(1, q);
        repeat (2 * CPB) @(negedge clk);
        compare_all(1, "after_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
